// File: rtl/mips_uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Device codes and addresses mirror the MIPS789 device controller map.
`default_nettype none

package mips_uart_loader_pkg;

    localparam logic [3:0]  DMEM_NOP = 4'd0;
    localparam logic [3:0]  DMEM_LBU = 4'd3;
    localparam logic [3:0]  DMEM_SW  = 4'd7;
    localparam logic [3:0]  DMEM_LW  = 4'd8;

    localparam logic [31:0] UART_DATA_ADDR = 32'h8000_0018;
    localparam logic [31:0] CMD_ADDR       = 32'h8000_001C;
    localparam logic [31:0] STATUS_ADDR    = 32'h8000_0020;

    localparam int STATUS_RX_RDY_BIT = 3;
    localparam int CMD_RXD_FT_BIT    = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_POLL, S_POLL_W, S_RD, S_RD_W, S_FT_SET, S_FT_CLR, S_PROC, S_FIN
    } state_t;

    typedef enum logic [1:0] {
        PH_LEN, PH_DATA, PH_CSUM
    } phase_t;

endpackage

`default_nettype wire

// File: rtl/mips_uart_loader_word_pack.sv
// Big-endian byte-to-word packer with running mod-256 checksum.
`default_nettype none

module loader_word_pack
    import mips_uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [7:0]  csum,
    output logic        last_byte,
    output logic        word_valid
);

    logic [1:0] cnt;

    assign last_byte = (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= 2'd0;
            word       <= 32'h0;
            csum       <= 8'h0;
            word_valid <= 1'b0;
        end else begin
            // Pulse lands the cycle after the fourth byte, once the word is complete
            word_valid <= en && last_byte && !clear;
            if (clear) begin
                cnt  <= 2'd0;
                csum <= 8'h0;
            end else if (en) begin
                word <= {word[23:0], byte_in};
                csum <= csum + byte_in;
                cnt  <= cnt + 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_uart_loader.sv
// UART boot loader: polls the device bus for rx bytes, decodes a
// length/data/checksum frame and writes the words into instruction memory.
`default_nettype none

module mips_uart_loader
    import mips_uart_loader_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] CMD_BASE = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              bus_req,
    output logic [31:0]       dvc_addr,
    output logic [3:0]        dvc_mem_ctl,
    output logic [31:0]       dvc_wdata,
    input  logic [31:0]       dvc_rdata,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              imem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
    localparam logic [31:0] FT_MASK   = 32'h1 << CMD_RXD_FT_BIT;

    state_t      state, next_state;
    phase_t      phase;
    logic [7:0]  rx_byte, len_hi, csum;
    logic        len_idx;
    logic [16:0] len_n, word_cnt, len_val;
    logic        proc_fin, pack_en, pack_clear, last_byte, word_valid;
    logic [31:0] word;
    logic        unused_rdata;

    assign unused_rdata = ^{dvc_rdata[31:8]};

    assign len_val    = {1'b0, len_hi, rx_byte};
    assign proc_fin   = (phase == PH_CSUM) ||
                        (phase == PH_LEN && len_idx && len_val > MAX_WORDS);
    assign pack_en    = (state == S_PROC) && (phase == PH_DATA);
    assign pack_clear = (state == S_IDLE) && start;

    assign busy       = (state != S_IDLE);
    assign bus_req    = busy;
    assign imem_we    = word_valid;
    assign imem_wdata = word;

    loader_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .en         (pack_en),
        .byte_in    (rx_byte),
        .word       (word),
        .csum       (csum),
        .last_byte  (last_byte),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state  = state;
        dvc_addr    = 32'h0;
        dvc_mem_ctl = DMEM_NOP;
        dvc_wdata   = 32'h0;
        case (state)
            S_IDLE:   if (start) next_state = S_POLL;
            S_POLL: begin
                dvc_addr    = STATUS_ADDR;
                dvc_mem_ctl = DMEM_LW;
                next_state  = S_POLL_W;
            end
            S_POLL_W: next_state = dvc_rdata[STATUS_RX_RDY_BIT] ? S_RD : S_POLL;
            S_RD: begin
                dvc_addr    = UART_DATA_ADDR;
                dvc_mem_ctl = DMEM_LBU;
                next_state  = S_RD_W;
            end
            S_RD_W:   next_state = S_FT_SET;
            S_FT_SET: begin
                dvc_addr    = CMD_ADDR;
                dvc_mem_ctl = DMEM_SW;
                dvc_wdata   = CMD_BASE | FT_MASK;
                next_state  = S_FT_CLR;
            end
            S_FT_CLR: begin
                dvc_addr    = CMD_ADDR;
                dvc_mem_ctl = DMEM_SW;
                dvc_wdata   = CMD_BASE & ~FT_MASK;
                next_state  = S_PROC;
            end
            S_PROC:   next_state = proc_fin ? S_FIN : S_POLL;
            S_FIN:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase     <= PH_LEN;
            rx_byte   <= 8'h0;
            len_hi    <= 8'h0;
            len_idx   <= 1'b0;
            len_n     <= 17'h0;
            word_cnt  <= 17'h0;
            imem_addr <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (word_valid) imem_addr <= imem_addr + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    imem_addr <= '0;
                    phase     <= PH_LEN;
                    len_idx   <= 1'b0;
                    word_cnt  <= 17'h0;
                end
                S_RD_W: rx_byte <= dvc_rdata[7:0];
                S_PROC: begin
                    if (proc_fin) done <= 1'b1;
                    case (phase)
                        PH_LEN: begin
                            if (!len_idx) begin
                                len_hi  <= rx_byte;
                                len_idx <= 1'b1;
                            end else begin
                                len_n <= len_val;
                                if (len_val > MAX_WORDS) err   <= 1'b1;
                                else if (len_val == 17'h0) phase <= PH_CSUM;
                                else                       phase <= PH_DATA;
                            end
                        end
                        PH_DATA: if (last_byte) begin
                            word_cnt <= word_cnt + 17'd1;
                            if (word_cnt + 17'd1 == len_n) phase <= PH_CSUM;
                        end
                        PH_CSUM: if (rx_byte != csum) err <= 1'b1;
                        default: phase <= PH_LEN;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
